// File: rtl/fft_r4_engine.sv
// In-place radix-4 GF(2^8) transform engine: load NPTS bytes, run LOG4N butterfly passes, stream the result.
// Define FFT_R4_INV_EN to build the inverse datapath selected by inv_i; otherwise inv_i is ignored.
module fft_r4_engine #(
   parameter int LOG4N = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 inv_i,
   input  logic [31:0]          din_i,
   input  logic                 din_valid_i,
   output logic                 din_ready_o,
   output logic [2*LOG4N-1:0]   tw_addr_o,
   input  logic [31:0]          tw_data_i,
   output logic [31:0]          dout_o,
   output logic                 dout_valid_o,
   input  logic                 dout_ready_i,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int NPTS  = 4 ** LOG4N;
   localparam int NGRP  = NPTS / 4;
   localparam int TW_AW = 2 * LOG4N;
   localparam int GW    = TW_AW - 2;
   localparam logic [GW-1:0] LAST_IDX  = GW'(NGRP - 1);
   localparam logic [1:0]    LAST_PASS = 2'(LOG4N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t          state;
   logic [GW-1:0]   beat;
   logic [GW-1:0]   grp;
   logic [1:0]      pass;
   logic            inv_mode;
   logic [7:0]      xbuf [NPTS];

   logic [3:0]       shamt;
   logic [TW_AW-1:0] grp_ext, low_mask, base;
   logic [TW_AW-1:0] idx [4];
   logic [7:0]       elem [4];
   logic [7:0]       twb [4];
   logic [7:0]       m_in [4];
   logic [7:0]       m_out [4];
   logic [7:0]       res [4];

`ifdef FFT_R4_INV_EN
   logic inv_q;
   assign inv_mode = inv_q;
`else
   logic unused_inv;
   assign inv_mode   = 1'b0;
   assign unused_inv = inv_i;
`endif

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
      end
      return acc;
   endfunction

   // Group g of pass p touches x[base + j*s] with s = 4^(LOG4N-1-p); since s is a power of
   // four the element index is just g with the two-bit j spliced in at bit position 2*(LOG4N-1-p).
   always_comb begin
      shamt    = 4'(2 * (LOG4N - 1 - int'(pass)));
      grp_ext  = TW_AW'(grp);
      low_mask = (TW_AW'(1) << shamt) - TW_AW'(1);
      base     = ((grp_ext >> shamt) << (shamt + 4'd2)) | (grp_ext & low_mask);
      for (int j = 0; j < 4; j++) begin
         idx[j]  = base | (TW_AW'(j) << shamt);
         elem[j] = xbuf[idx[j]];
         twb[j]  = tw_data_i[31-8*j -: 8];
      end
      if (inv_mode) begin
         m_in[0] = elem[0];
         m_in[1] = elem[1] ^ elem[2];
         m_in[2] = elem[2] ^ elem[3];
         m_in[3] = elem[3];
      end else begin
         for (int j = 0; j < 4; j++) m_in[j] = elem[j];
      end
      for (int j = 0; j < 4; j++) m_out[j] = gf_mul(m_in[j], twb[j]);
      if (inv_mode) begin
         for (int j = 0; j < 4; j++) res[j] = m_out[j];
      end else begin
         res[0] = m_out[0];
         res[1] = m_out[1] ^ m_out[2] ^ m_out[3];
         res[2] = m_out[2] ^ m_out[3];
         res[3] = m_out[3];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         beat   <= '0;
         grp    <= '0;
         pass   <= '0;
         done_o <= 1'b0;
`ifdef FFT_R4_INV_EN
         inv_q  <= 1'b0;
`endif
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: if (start_i) begin
               state <= LOAD;
               beat  <= '0;
`ifdef FFT_R4_INV_EN
               inv_q <= inv_i;
`endif
            end
            LOAD: if (din_valid_i) begin
               beat <= beat + GW'(1);
               if (beat == LAST_IDX) begin
                  state <= CALC;
                  grp   <= '0;
                  pass  <= inv_mode ? LAST_PASS : 2'd0;
               end
            end
            CALC: begin
               grp <= grp + GW'(1);
               if (grp == LAST_IDX) begin
                  if (pass == (inv_mode ? 2'd0 : LAST_PASS)) begin
                     state <= OUT;
                     beat  <= '0;
                  end else begin
                     pass <= inv_mode ? pass - 2'd1 : pass + 2'd1;
                  end
               end
            end
            OUT: if (dout_ready_i) begin
               beat <= beat + GW'(1);
               if (beat == LAST_IDX) begin
                  state  <= IDLE;
                  done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The buffer is never reset: an abandoned job leaves stale bytes that the next LOAD overwrites.
   always_ff @(posedge clk_i) begin
      if (state == LOAD && din_valid_i) begin
         for (int j = 0; j < 4; j++) xbuf[{beat, 2'(j)}] <= din_i[31-8*j -: 8];
      end else if (state == CALC) begin
         for (int j = 0; j < 4; j++) xbuf[idx[j]] <= res[j];
      end
   end

   assign busy_o       = (state != IDLE);
   assign din_ready_o  = (state == LOAD);
   assign dout_valid_o = (state == OUT);
   assign tw_addr_o    = (state == CALC) ? {pass, grp} : '0;
   assign dout_o       = (state == OUT) ?
                         {xbuf[{beat, 2'd0}], xbuf[{beat, 2'd1}], xbuf[{beat, 2'd2}], xbuf[{beat, 2'd3}]} : '0;
endmodule

// File: tb/tb_fft_r4_engine.sv
// Self-checking bench for fft_r4_engine: directed vectors plus randomized jobs against a behavioural model.
// Inverse-mode vectors are exercised only when FFT_R4_INV_EN is defined.
module tb_fft_r4_engine;
   localparam int LOG4N = 2;
   localparam int NPTS  = 4 ** LOG4N;
   localparam int NGRP  = NPTS / 4;
   localparam int AW    = 2 * LOG4N;
`ifdef FFT_R4_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i, inv_i, din_valid_i, dout_ready_i;
   logic [31:0]   din_i, tw_data_i, dout_o;
   logic          din_ready_o, dout_valid_o, busy_o, done_o;
   logic [AW-1:0] tw_addr_o;

   logic [31:0]   tw_tab [NPTS];
   logic [7:0]    in_x [NPTS];
   logic [7:0]    exp_x [NPTS];
   logic [31:0]   exp_q [$];
   int            n_cmp = 0;
   int            n_fail = 0;
   int            calc_cnt = 0;
   int            done_cnt = 0;
   int            jobs_done = 0;
   bit            job_inv = 1'b0;
   bit            done_pending = 1'b0;
   bit            prev_valid = 1'b0;

   fft_r4_engine #(.LOG4N(LOG4N)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .inv_i(inv_i),
      .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
      .tw_addr_o(tw_addr_o), .tw_data_i(tw_data_i),
      .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
      .busy_o(busy_o), .done_o(done_o)
   );

   // Twiddle ROM answers the address in the same cycle.
   assign tw_data_i = tw_tab[tw_addr_o];

   always #5 clk_i = ~clk_i;

   function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   // Carry-less product followed by long division by x^8+x^4+x^3+x^2+1.
   function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11D << (i - 8));
      return prod[7:0];
   endfunction

   function automatic void run_model(input bit inv);
      logic [7:0]  x [NPTS];
      logic [7:0]  av [4];
      logic [7:0]  cv [4];
      logic [7:0]  rv [4];
      logic [31:0] tw;
      int p, s, base;
      for (int i = 0; i < NPTS; i++) x[i] = in_x[i];
      for (int step = 0; step < LOG4N; step++) begin
         p = inv ? (LOG4N - 1 - step) : step;
         s = 4 ** (LOG4N - 1 - p);
         for (int g = 0; g < NGRP; g++) begin
            base = (g / s) * 4 * s + g % s;
            tw   = tw_tab[p * NGRP + g];
            for (int j = 0; j < 4; j++) av[j] = x[base + j * s];
            if (inv) begin
               cv = '{av[0], av[1] ^ av[2], av[2] ^ av[3], av[3]};
               for (int j = 0; j < 4; j++) rv[j] = gf_ref(cv[j], tw[31-8*j -: 8]);
            end else begin
               for (int j = 0; j < 4; j++) cv[j] = gf_ref(av[j], tw[31-8*j -: 8]);
               rv = '{cv[0], cv[1] ^ cv[2] ^ cv[3], cv[2] ^ cv[3], cv[3]};
            end
            for (int j = 0; j < 4; j++) x[base + j * s] = rv[j];
         end
      end
      for (int i = 0; i < NPTS; i++) exp_x[i] = x[i];
   endfunction

   // Per-cycle checker: twiddle address sequence and CALC length, output beats against the
   // expected queue, and the done pulse one cycle after the final output handshake.
   always @(negedge clk_i) begin
      int pexp;
      if (din_ready_o) begin
         calc_cnt = 0;
      end else if (busy_o && !dout_valid_o) begin
         check_output("calc_overrun", 32'(calc_cnt < LOG4N * NGRP), 32'd1);
         pexp = job_inv ? (LOG4N - 1 - calc_cnt / NGRP) : (calc_cnt / NGRP);
         check_output("tw_addr", 32'(tw_addr_o), 32'(AW'(pexp * NGRP + calc_cnt % NGRP)));
         calc_cnt++;
      end else begin
         check_output("tw_addr_idle", 32'(tw_addr_o), 32'd0);
      end
      if (dout_valid_o && !prev_valid) check_output("calc_len", calc_cnt, LOG4N * NGRP);
      check_output("done_o", 32'(done_o), 32'(done_pending));
      if (done_pending) check_output("busy_at_done", 32'(busy_o), 32'd0);
      if (done_o) done_cnt++;
      done_pending = 1'b0;
      if (dout_valid_o) begin
         if (exp_q.size() == 0) begin
            check_output("dout_extra_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            check_output("dout", dout_o, exp_q[0]);
            if (dout_ready_i) begin
               void'(exp_q.pop_front());
               done_pending = (exp_q.size() == 0);
            end
         end
      end else begin
         check_output("dout_idle_zero", dout_o, 32'd0);
      end
      prev_valid = dout_valid_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_vecs();
      for (int i = 0; i < NPTS; i++) begin
         in_x[i]  = 8'h00;
         exp_x[i] = 8'h00;
      end
   endtask

   task automatic set_tw(input logic [31:0] w);
      for (int i = 0; i < NPTS; i++) tw_tab[i] = w;
   endtask

   task automatic push_beat(input logic [31:0] w);
      din_i       = w;
      din_valid_i = 1'b1;
      @(negedge clk_i);
      check_output("din_ready", 32'(din_ready_o), 32'd1);
      tick();
      din_valid_i = 1'b0;
   endtask

   // Starts a job, loads in_x with random gaps, then drives junk start/din that must be ignored.
   task automatic apply_stimulus(input bit inv);
      for (int b = 0; b < NGRP; b++)
         exp_q.push_back({exp_x[4*b], exp_x[4*b+1], exp_x[4*b+2], exp_x[4*b+3]});
      job_inv     = inv & INV_EN;
      din_valid_i = 1'b0;
      start_i     = 1'b1;
      inv_i       = inv;
      tick();
      start_i = 1'b0;
      inv_i   = 1'($urandom_range(0, 1));
      check_output("start_busy", 32'(busy_o), 32'd1);
      for (int b = 0; b < NGRP; b++) begin
         repeat ($urandom_range(0, 1)) tick();
         push_beat({in_x[4*b], in_x[4*b+1], in_x[4*b+2], in_x[4*b+3]});
      end
      din_valid_i = 1'b1;
      din_i       = $urandom;
      start_i     = 1'b1;
      repeat (3) tick();
      start_i = 1'b0;
   endtask

   task automatic drain(input int stall_beat, input int stall_len, input bit b2b);
      int guard, stalled, beat;
      guard   = 0;
      stalled = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         beat = NGRP - exp_q.size();
         if (dout_valid_o && beat == stall_beat && stalled < stall_len) begin
            dout_ready_i = 1'b0;
            stalled++;
         end else begin
            dout_ready_i = ($urandom_range(0, 3) != 0);
         end
         tick();
         guard++;
      end
      check_output("drain_timeout", 32'(guard < 300), 32'd1);
      exp_q.delete();
      dout_ready_i = 1'b0;
      jobs_done++;
      if (!b2b) begin
         tick();
         tick();
         check_output("done_count", done_cnt, jobs_done);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      start_i = 1'b0; inv_i = 1'b0; din_valid_i = 1'b0; dout_ready_i = 1'b0; din_i = '0;
      set_tw(32'h01010101);
      rst_i = 1'b1;
      #2;
      check_output("rst_busy", 32'(busy_o), 32'd0);
      check_output("rst_din_ready", 32'(din_ready_o), 32'd0);
      check_output("rst_dout_valid", 32'(dout_valid_o), 32'd0);
      check_output("rst_done", 32'(done_o), 32'd0);
      check_output("rst_dout", dout_o, 32'd0);
      check_output("rst_tw_addr", 32'(tw_addr_o), 32'd0);
      tick();
      tick();
      rst_i = 1'b0;
      tick();

      // Model pinned to hand-computed values.
      check_output("gf_80x02", 32'(gf_ref(8'h80, 8'h02)), 32'h1D);
      check_output("gf_80x04", 32'(gf_ref(8'h80, 8'h04)), 32'h3A);
      check_output("gf_57x01", 32'(gf_ref(8'h57, 8'h01)), 32'h57);
      clear_vecs(); in_x[3] = 8'h01; run_model(1'b0);
      check_output("model_fwd_x0", 32'(exp_x[0]), 32'h00);
      check_output("model_fwd_x1", 32'(exp_x[1]), 32'h01);
      check_output("model_fwd_x3", 32'(exp_x[3]), 32'h01);
      clear_vecs(); in_x[1] = 8'h01; in_x[2] = 8'h01; in_x[3] = 8'h01; run_model(1'b1);
      check_output("model_inv_x1", 32'(exp_x[1]), 32'h00);
      check_output("model_inv_x3", 32'(exp_x[3]), 32'h01);
      set_tw(32'h01020202); clear_vecs(); in_x[1] = 8'h80; run_model(1'b0);
      check_output("model_mul_x1", 32'(exp_x[1]), 32'h1D);

      // All-zero input stays zero.
      set_tw(32'h01010101); clear_vecs();
      apply_stimulus(1'b0); drain(-1, 0, 1'b0);
      // Single impulse at x[3].
      clear_vecs(); in_x[3] = 8'h01; exp_x[1] = 8'h01; exp_x[2] = 8'h01; exp_x[3] = 8'h01;
      apply_stimulus(1'b0); drain(-1, 0, 1'b0);
      // Multiplier reduction through 0x11D.
      set_tw(32'h01020202); clear_vecs(); in_x[1] = 8'h80; exp_x[1] = 8'h1D;
      apply_stimulus(1'b0); drain(-1, 0, 1'b0);
`ifdef FFT_R4_INV_EN
      set_tw(32'h01010101); clear_vecs();
      in_x[1] = 8'h01; in_x[2] = 8'h01; in_x[3] = 8'h01; exp_x[3] = 8'h01;
      apply_stimulus(1'b1); drain(-1, 0, 1'b0);
`endif
      // Five-cycle backpressure during beat 2.
      set_tw(32'h01010101); clear_vecs();
      in_x[3] = 8'h01; exp_x[1] = 8'h01; exp_x[2] = 8'h01; exp_x[3] = 8'h01;
      apply_stimulus(1'b0); drain(2, 5, 1'b0);

      // Reset in the middle of CALC abandons the job.
      for (int i = 0; i < NPTS; i++) in_x[i] = 8'($urandom);
      apply_stimulus(1'b0);
      rst_i = 1'b1;
      #1;
      check_output("midrst_busy", 32'(busy_o), 32'd0);
      check_output("midrst_tw_addr", 32'(tw_addr_o), 32'd0);
      check_output("midrst_dout_valid", 32'(dout_valid_o), 32'd0);
      exp_q.delete();
      tick();
      rst_i = 1'b0;
      tick();
      clear_vecs(); in_x[3] = 8'h01; exp_x[1] = 8'h01; exp_x[2] = 8'h01; exp_x[3] = 8'h01;
      apply_stimulus(1'b0); drain(-1, 0, 1'b0);

      // Randomized jobs; some start in the done cycle of the previous job.
      for (int k = 0; k < 16; k++) begin
         bit inv;
         inv = 1'($urandom_range(0, 1));
         for (int i = 0; i < NPTS; i++) begin
            tw_tab[i] = $urandom;
            in_x[i]   = 8'($urandom);
         end
         run_model(inv & INV_EN);
         apply_stimulus(inv);
         drain($urandom_range(0, NGRP), $urandom_range(0, 4), (k % 3 == 1) && (k != 15));
      end

      check_output("done_total", done_cnt, jobs_done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
